game_sequencer: RTL and testbench

- Parametrised successor to the game frame-control FSM.
- Sequences one game frame: init, idle wait, movement generation, collision check, apply actions, then draw map, Link and each live enemy.
- Adds per-enemy draw iteration over N_ENEMY slots, skipping dead slots, plus pause, a game-over state, a frame counter and an optional stall watchdog.
- Sits between the frame timer/datapath done signals and the datapath/VGA draw engines.

---
 rtl/game_seq_pkg.sv | 23 ++
 rtl/seq_next_alive.sv | 28 ++
 rtl/game_sequencer.sv | 177 +++++++++++++++++
 tb/tb_game_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_seq_pkg.sv
// game_seq_pkg: state codes, on/off constants and enemy_sel width helper
// shared by game_sequencer and its next-alive search.
package game_seq_pkg;

    localparam logic [3:0] S_INIT          = 4'd0;
    localparam logic [3:0] S_IDLE          = 4'd1;
    localparam logic [3:0] S_GEN_MOVEMENT  = 4'd2;
    localparam logic [3:0] S_CHECK_COLLIDE = 4'd3;
    localparam logic [3:0] S_LINK_ACTION   = 4'd4;
    localparam logic [3:0] S_MOVE_ENEMIES  = 4'd5;
    localparam logic [3:0] S_DRAW_MAP      = 4'd6;
    localparam logic [3:0] S_DRAW_LINK     = 4'd7;
    localparam logic [3:0] S_DRAW_ENEMIES  = 4'd8;
    localparam logic [3:0] S_GAME_OVER     = 4'd9;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_next_alive.sv
// seq_next_alive: lowest alive slot strictly above from_idx, or the
// lowest alive slot overall when from_start is set.
module seq_next_alive
    import game_seq_pkg::*;
#(
    parameter int N = 4,
    parameter int W = sel_width(N)
) (
    input  logic [N-1:0] alive,
    input  logic [W-1:0] from_idx,
    input  logic         from_start,
    output logic [W-1:0] next_idx,
    output logic         found
);

    // Descending scan: the last hit written is the lowest qualifying index.
    always_comb begin
        next_idx = '0;
        found    = OFF;
        for (int i = N - 1; i >= 0; i--) begin
            if (alive[i] && (from_start || i > int'(from_idx))) begin
                next_idx = i[W-1:0];
                found    = ON;
            end
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: per-frame control FSM with enemy draw iteration, pause,
// game-over and frame counter. Define SEQ_WATCHDOG_EN for the stall watchdog.
module game_sequencer
    import game_seq_pkg::*;
#(
    parameter int          N_ENEMY        = 4,
    parameter int          FRAME_W        = 16,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd800000,
    localparam int         SEL_W          = sel_width(N_ENEMY)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               idle_done,
    input  logic               pause,
    input  logic               check_collide_done,
    input  logic               link_dead,
    input  logic               restart,
    input  logic               draw_map_done,
    input  logic               draw_link_done,
    input  logic               draw_enemy_done,
    input  logic [N_ENEMY-1:0] enemy_alive,
    output logic [3:0]         states,
    output logic               init,
    output logic               idle,
    output logic               gen_move,
    output logic               check_collide,
    output logic               apply_act_link,
    output logic               move_enemies,
    output logic               draw_map,
    output logic               draw_link,
    output logic               draw_enemies,
    output logic               game_over,
    output logic [SEL_W-1:0]   enemy_sel,
    output logic [FRAME_W-1:0] frame_count,
    output logic               timeout_err
);

    localparam logic [FRAME_W-1:0] FRAME_ONE = FRAME_W'(1);

    logic [3:0]       state;
    logic [3:0]       next_state;
    logic [SEL_W-1:0] nxt_idx;
    logic             nxt_found;
    logic             wd_fire;
    logic             collide_go;
    logic             map_go;
    logic             link_go;
    logic             enemy_go;
    logic             in_link;
    logic             in_enemies;
    logic             sel_load;
    logic             frame_done;

    seq_next_alive #(
        .N (N_ENEMY),
        .W (SEL_W)
    ) u_next (
        .alive      (enemy_alive),
        .from_idx   (enemy_sel),
        .from_start (in_link),
        .next_idx   (nxt_idx),
        .found      (nxt_found)
    );

    // wd_fire is only ever high inside a wait state, so OR-ing it into
    // every done is safe: each done is consulted only in its own state.
    assign collide_go = check_collide_done | wd_fire;
    assign map_go     = draw_map_done | wd_fire;
    assign link_go    = draw_link_done | wd_fire;
    assign enemy_go   = draw_enemy_done | wd_fire;

    assign in_link    = (state == S_DRAW_LINK);
    assign in_enemies = (state == S_DRAW_ENEMIES);

    assign sel_load   = ((in_link && link_go) || (in_enemies && enemy_go))
                        && nxt_found;
    assign frame_done = ((in_link && link_go) || (in_enemies && enemy_go))
                        && !nxt_found;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_INIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_INIT:          next_state = S_DRAW_MAP;
            S_IDLE:
                if (idle_done && !pause) next_state = S_GEN_MOVEMENT;
            S_GEN_MOVEMENT:  next_state = S_CHECK_COLLIDE;
            S_CHECK_COLLIDE:
                if (collide_go) next_state = S_LINK_ACTION;
            S_LINK_ACTION:
                next_state = link_dead ? S_GAME_OVER : S_MOVE_ENEMIES;
            S_MOVE_ENEMIES:  next_state = S_DRAW_MAP;
            S_DRAW_MAP:
                if (map_go) next_state = S_DRAW_LINK;
            S_DRAW_LINK:
                if (link_go) next_state = nxt_found ? S_DRAW_ENEMIES : S_IDLE;
            S_DRAW_ENEMIES:
                if (enemy_go && !nxt_found) next_state = S_IDLE;
            S_GAME_OVER:
                if (restart) next_state = S_INIT;
            default:         next_state = S_IDLE;
        endcase
    end

    always_comb begin
        init           = OFF;
        idle           = OFF;
        gen_move       = OFF;
        check_collide  = OFF;
        apply_act_link = OFF;
        move_enemies   = OFF;
        draw_map       = OFF;
        draw_link      = OFF;
        draw_enemies   = OFF;
        game_over      = OFF;
        case (state)
            S_INIT:          init           = ON;
            S_IDLE:          idle           = ON;
            S_GEN_MOVEMENT:  gen_move       = ON;
            S_CHECK_COLLIDE: check_collide  = ON;
            S_LINK_ACTION:   apply_act_link = ON;
            S_MOVE_ENEMIES:  move_enemies   = ON;
            S_DRAW_MAP:      draw_map       = ON;
            S_DRAW_LINK:     draw_link      = ON;
            S_DRAW_ENEMIES:  draw_enemies   = ON;
            S_GAME_OVER:     game_over      = ON;
            default: ;
        endcase
    end

    assign states = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enemy_sel   <= '0;
            frame_count <= '0;
        end else begin
            if (sel_load) enemy_sel <= nxt_idx;
            if (frame_done) frame_count <= frame_count + FRAME_ONE;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    logic [19:0] wd_cnt;
    logic        wd_wait;

    assign wd_wait = (state == S_CHECK_COLLIDE) || (state == S_DRAW_MAP)
                  || in_link || in_enemies;
    assign wd_fire = wd_wait && (wd_cnt == TIMEOUT_CYCLES - 20'd1);

    // Each enemy draw gets a fresh budget, not just each state entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_cnt      <= '0;
            timeout_err <= OFF;
        end else begin
            if (next_state != state || sel_load) begin
                wd_cnt <= '0;
            end else if (wd_wait) begin
                wd_cnt <= wd_cnt + 20'd1;
            end
            if (wd_fire) timeout_err <= ON;
        end
    end
`else
    assign wd_fire     = OFF;
    assign timeout_err = OFF;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: randomized frame sequences checked against a
// queue-based model of the draw order and frame count.
module tb_game_sequencer;

    logic        clock = 0;
    logic        reset = 0;
    logic        idle_done = 0;
    logic        pause = 0;
    logic        check_collide_done = 0;
    logic        link_dead = 0;
    logic        restart = 0;
    logic        draw_map_done = 0;
    logic        draw_link_done = 0;
    logic        draw_enemy_done = 0;
    logic [3:0]  enemy_alive = 0;
    logic [3:0]  states;
    logic        init, idle, gen_move, check_collide, apply_act_link;
    logic        move_enemies, draw_map, draw_link, draw_enemies, game_over;
    logic [1:0]  enemy_sel;
    logic [15:0] frame_count;
    logic        timeout_err;

    int total = 0;
    int bad = 0;
    int frames = 0;

    game_sequencer #(
        .N_ENEMY        (4),
        .FRAME_W        (16),
        .TIMEOUT_CYCLES (20'd16)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .idle_done          (idle_done),
        .pause              (pause),
        .check_collide_done (check_collide_done),
        .link_dead          (link_dead),
        .restart            (restart),
        .draw_map_done      (draw_map_done),
        .draw_link_done     (draw_link_done),
        .draw_enemy_done    (draw_enemy_done),
        .enemy_alive        (enemy_alive),
        .states             (states),
        .init               (init),
        .idle               (idle),
        .gen_move           (gen_move),
        .check_collide      (check_collide),
        .apply_act_link     (apply_act_link),
        .move_enemies       (move_enemies),
        .draw_map           (draw_map),
        .draw_link          (draw_link),
        .draw_enemies       (draw_enemies),
        .game_over          (game_over),
        .enemy_sel          (enemy_sel),
        .frame_count        (frame_count),
        .timeout_err        (timeout_err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input int exp);
        logic [9:0] oh;
        oh = {game_over, draw_enemies, draw_link, draw_map, move_enemies,
              apply_act_link, check_collide, gen_move, idle, init};
        chk("state", 32'(states), 32'(exp));
        chk("strobe", 32'(oh), 32'(1) << exp);
    endtask

    task automatic draw_phase(input logic [3:0] mask);
        int q[$];
        int cur;
        check_state(6);
        repeat ($urandom_range(0, 3)) begin
            draw_link_done  = 1'($urandom_range(0, 1));
            draw_enemy_done = 1'($urandom_range(0, 1));
            restart         = 1'($urandom_range(0, 1));
            step();
            check_state(6);
        end
        draw_link_done = 0;
        draw_enemy_done = 0;
        restart = 0;
        draw_map_done = 1;
        step();
        draw_map_done = 0;
        check_state(7);
        enemy_alive = mask;
        repeat ($urandom_range(0, 3)) begin
            step();
            check_state(7);
        end
        for (int i = 0; i < 4; i++) if (mask[i]) q.push_back(i);
        draw_link_done = 1;
        step();
        draw_link_done = 0;
        while (q.size() > 0) begin
            cur = q.pop_front();
            check_state(8);
            chk("enemy_sel", 32'(enemy_sel), 32'(cur));
            repeat ($urandom_range(0, 3)) begin
                step();
                check_state(8);
                chk("sel_hold", 32'(enemy_sel), 32'(cur));
            end
            if ($urandom_range(0, 1) == 1) enemy_alive[cur] = 1'b0;
            draw_enemy_done = 1;
            step();
            draw_enemy_done = 0;
        end
        frames++;
        check_state(1);
        chk("frame_count", 32'(frame_count), 32'(frames & 16'hffff));
        chk("timeout_err", 32'(timeout_err), 0);
    endtask

    task automatic idle_phase(input logic dead, input int hold);
        check_state(1);
        repeat ($urandom_range(0, 3)) begin
            draw_enemy_done = 1'($urandom_range(0, 1));
            restart         = 1'($urandom_range(0, 1));
            step();
            check_state(1);
        end
        draw_enemy_done = 0;
        restart = 0;
        pause = 1;
        idle_done = 1;
        repeat (hold) begin
            step();
            check_state(1);
        end
        pause = 0;
        step();
        idle_done = 0;
        check_state(2);
        step();
        check_state(3);
        repeat ($urandom_range(0, 3)) begin
            step();
            check_state(3);
        end
        check_collide_done = 1;
        step();
        check_collide_done = 0;
        check_state(4);
        link_dead = dead;
        step();
        link_dead = 0;
        if (dead) begin
            check_state(9);
            repeat ($urandom_range(1, 4)) begin
                draw_map_done = 1'($urandom_range(0, 1));
                idle_done     = 1'($urandom_range(0, 1));
                step();
                check_state(9);
            end
            draw_map_done = 0;
            idle_done = 0;
            restart = 1;
            step();
            restart = 0;
            check_state(0);
            step();
        end else begin
            check_state(5);
            step();
        end
        check_state(6);
    endtask

    initial begin
        int cyc;
        repeat (3) step();
        check_state(0);
        chk("rst_sel", 32'(enemy_sel), 0);
        chk("rst_frame", 32'(frame_count), 0);
        chk("rst_terr", 32'(timeout_err), 0);
        reset = 1;
        step();
        draw_phase(4'b1111);
        idle_phase(1'b0, 10);
        draw_phase(4'b1010);
        idle_phase(1'b0, 2);
        draw_phase(4'b0000);
        idle_phase(1'b1, 1);
        draw_phase(4'b0001);
        for (int k = 0; k < 20; k++) begin
            idle_phase(1'($urandom_range(0, 3) == 0), $urandom_range(0, 4));
            draw_phase(4'($urandom_range(0, 15)));
        end
        idle_phase(1'b0, 0);
`ifdef SEQ_WATCHDOG_EN
        cyc = 0;
        while (states == 4'd6 && cyc < 40) begin
            step();
            cyc++;
        end
        chk("wd_cycles", 32'(cyc), 16);
        check_state(7);
        chk("wd_terr", 32'(timeout_err), 1);
        repeat (2) step();
        chk("wd_sticky", 32'(timeout_err), 1);
`else
        cyc = 0;
        draw_map_done = 1;
        step();
        draw_map_done = 0;
        check_state(7);
        chk("terr_tied", 32'(timeout_err), 0);
`endif
        #3 reset = 0;
        #1;
        check_state(0);
        chk("arst_frame", 32'(frame_count), 0);
        chk("arst_sel", 32'(enemy_sel), 0);
        chk("arst_terr", 32'(timeout_err), 0);
        step();
        check_state(0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
